// File: rtl/booth_mul_sequencer_if.sv
// rtl/booth_mul_sequencer_if.sv - operand/result handshake bundle for the Booth multiplier
interface booth_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Q;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, M, Q,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, M, Q,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - radix-4 Booth multiplier, one bit-pair per clock
module booth_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    booth_mul_sequencer_if.slave bus
);
    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic [WIDTH:0]   qreg_q, qreg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [CW:0]      shamt;
    logic [2:0]       triple;
    logic [PW-1:0]    m_ext;
    logic [PW-1:0]    m_sh;
    logic [PW-1:0]    addend;
    logic             sub;
    logic [PW-1:0]    sum;

    // Recode the current pair; qreg carries the implicit q[-1]=0 in bit 0.
    always_comb begin
        shamt  = {count_q, 1'b0};
        triple = qreg_q[shamt +: 3];
        m_ext  = {{WIDTH{mreg_q[WIDTH-1]}}, mreg_q};
        m_sh   = m_ext << shamt;
        addend = '0;
        sub    = 1'b0;
        case (triple)
            3'b001, 3'b010: addend = m_sh;
            3'b011:         addend = m_sh << 1;
            3'b100: begin
                addend = m_sh << 1;
                sub    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = m_sh;
                sub    = 1'b1;
            end
            default:        addend = '0;
        endcase
        sum = sub ? (acc_q - addend) : (acc_q + addend);
    end

    always_comb begin
        state_d = state_q;
        mreg_d  = mreg_q;
        qreg_d  = qreg_q;
        acc_d   = acc_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mreg_d  = bus.M;
                    qreg_d  = {bus.Q, 1'b0};
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = sum;
                count_d = count_q + 1'b1;
                if (count_q == CW'(PAIRS - 1)) begin
                    hi_d    = sum[PW-1:WIDTH];
                    lo_d    = sum[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            mreg_q  <= '0;
            qreg_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mreg_q  <= mreg_d;
            qreg_q  <= qreg_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done  = (state_q == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
